// File: rtl/fifo_apb_master.sv
// fifo_apb_master: drains command words from the read side of the async command
// FIFO and executes each one as an APB3 master transfer, returning one response
// per command.
//   rclk, rrst_n           read-domain clock, asynchronous active-low reset
//   fifo_rdata/rempty/rinc FWFT FIFO head word, empty flag, combinational pop strobe
//   psel..pwdata           registered APB3 master request outputs
//   prdata/pready/pslverr  APB3 completer return signals
//   rsp_*                  one-cycle response strobe with held read data, error, direction
//   busy                   a transfer is in progress
module fifo_apb_master #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CMD_W   = 1 + AW + DW,
  parameter int TIMEOUT = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [CMD_W-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  input  logic [DW-1:0]    prdata,
  input  logic             pready,
  input  logic             pslverr,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             rsp_write,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic        w_done, w_abort, w_pop;
  // A completing ACCESS may pop the next word directly, skipping IDLE so
  // back-to-back zero-wait transfers take two cycles each.
  always_comb begin
    w_done  = r_state == ACCESS && pready;
    w_abort = r_state == ACCESS && !pready && TIMEOUT != 0 && r_cnt == TO_LAST;
    w_pop   = rrst_n && !fifo_rempty && (r_state == IDLE || w_done);
    w_next  = w_pop ? SETUP : r_state == SETUP ? ACCESS : (w_done || w_abort) ? IDLE : r_state;
  end
  assign fifo_rinc = w_pop;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_write <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy      <= w_next != IDLE;
      rsp_valid <= w_done || w_abort;
      if (w_pop) begin
        pwrite  <= fifo_rdata[CMD_W-1];
        paddr   <= fifo_rdata[AW+DW-1:DW];
        pwdata  <= fifo_rdata[DW-1:0];
        psel    <= 1'b1;
        penable <= 1'b0;
      end else if (r_state == SETUP) begin
        penable <= 1'b1;
        r_cnt   <= '0;
      end else if (w_done || w_abort) begin
        psel    <= 1'b0;
        penable <= 1'b0;
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt + 16'(r_cnt != 16'hFFFF);
      end
      // A timed-out read returns zero data and always flags an error.
      if (w_done || w_abort) begin
        rsp_write <= pwrite;
        rsp_err   <= w_abort || pslverr;
        rsp_rdata <= (w_done && !pwrite && !pslverr) ? prdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_apb_master.sv
// tb_fifo_apb_master: randomized and directed bench with a queue-based FIFO/slave/response model
module tb_fifo_apb_master;
  localparam int AW = 8, DW = 8, CW = 1 + AW + DW, TO = 4;
  logic          rclk = 0, rrst_n = 1;
  logic [CW-1:0] fifo_rdata = '0;
  logic          fifo_rempty = 1, fifo_rinc;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata = '0, rsp_rdata;
  logic          pready = 0, pslverr = 0, rsp_valid, rsp_err, rsp_write, busy;

  fifo_apb_master #(.AW(AW), .DW(DW), .CMD_W(CW), .TIMEOUT(TO)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_write(rsp_write), .busy(busy)
  );

  always #5 rclk = ~rclk;

  typedef struct {int waits; logic err; logic [DW-1:0] rd;} plan_t;
  typedef struct {logic w; logic e; logic [DW-1:0] d;} rsp_t;
  logic [CW-1:0] q[$], cmd_q[$], cur = '0;
  plan_t         plan_q[$], cp;
  rsp_t          rsp_q[$];
  int            acc = 0, exp_acc = 0, n_rsp = 0, n_push = 0, checks = 0, errors = 0;
  bit            pop_pend = 0, in_acc = 0;
  logic [63:0]   tr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic plan(input int waits, input logic err, input logic [DW-1:0] rd);
    plan_t p;
    p.waits = waits; p.err = err; p.rd = rd;
    plan_q.push_back(p);
  endtask

  task automatic drive_fifo();
    fifo_rempty = q.size() == 0;
    fifo_rdata  = q.size() != 0 ? q[0] : '0;
  endtask

  // One cycle: check outputs of the last edge, play slave and FIFO for the next edge.
  task automatic step();
    rsp_t e;
    bit   setup, access;
    logic exp_rinc;
    @(negedge rclk);
    if (pop_pend) begin q.delete(0); pop_pend = 0; end
    setup  = psel && !penable;
    access = psel && penable;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) chk("rsp_spurious", 32'(rsp_valid), 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_write", 32'(rsp_write), 32'(e.w));
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
        n_rsp++;
      end
    end
    if (in_acc && !access) chk("acc_len", acc, exp_acc);
    in_acc = access;
    if (setup) begin
      chk("setup_busy", 32'(busy), 1);
      if (cmd_q.size() == 0) chk("setup_without_pop", 32'(setup), 0);
      else begin
        cur = cmd_q.pop_front();
        if (plan_q.size() != 0) cp = plan_q.pop_front();
        else begin
          cp.waits = $urandom_range(0, 5);
          cp.err   = $urandom_range(0, 3) == 0;
          cp.rd    = DW'($urandom);
        end
        acc     = 0;
        exp_acc = cp.waits >= TO ? TO : cp.waits + 1;
        e.w = cur[CW-1];
        e.e = cp.waits >= TO || cp.err;
        e.d = (!e.w && !e.e) ? cp.rd : '0;
        rsp_q.push_back(e);
      end
    end
    if (psel) begin
      chk("pwrite", 32'(pwrite), 32'(cur[CW-1]));
      chk("paddr", 32'(paddr), 32'(cur[CW-2:DW]));
      chk("pwdata", 32'(pwdata), 32'(cur[DW-1:0]));
    end
    if (access) begin
      acc++;
      pready  = acc == cp.waits + 1;
      pslverr = pready ? cp.err : 1'($urandom);
      prdata  = pready ? cp.rd : DW'($urandom);
    end else begin
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = DW'($urandom);
    end
    drive_fifo();
    #1;
    exp_rinc = rrst_n && !fifo_rempty && (!psel || (access && pready));
    chk("rinc", 32'(fifo_rinc), 32'(exp_rinc));
    if (fifo_rinc && q.size() != 0) begin
      cmd_q.push_back(q[0]);
      pop_pend = 1;
    end
    tr = {tr[59:0], psel, penable, rsp_valid, fifo_rinc};
  endtask

  // Asynchronous reset asserted just after a negedge, held cyc cycles, released at a negedge.
  task automatic do_reset(input int cyc);
    rrst_n = 0;
    #1;
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", 32'(pwdata), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_write", 32'(rsp_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rinc", 32'(fifo_rinc), 0);
    cmd_q.delete(); rsp_q.delete();
    pop_pend = 0; in_acc = 0; acc = 0;
    repeat (cyc) begin
      @(negedge rclk);
      drive_fifo();
      #1;
      chk("rst_hold_rinc", 32'(fifo_rinc), 0);
      chk("rst_hold_psel", 32'(psel), 0);
    end
    @(negedge rclk);
    rrst_n = 1;
    drive_fifo();
    #1;
    chk("rst_release_rinc", 32'(fifo_rinc), 32'(q.size() != 0));
    if (fifo_rinc && q.size() != 0) begin
      cmd_q.push_back(q[0]);
      pop_pend = 1;
    end
  endtask

  initial begin
    #2;
    do_reset(2);
    // zero-wait write
    q.push_back({1'b1, 8'h3C, 8'hA5}); plan(0, 0, 8'h00);
    repeat (5) step();
    chk("zw_trace", tr[19:0], 32'h18C20);
    // read with two wait states
    q.push_back({1'b0, 8'h10, 8'h00}); plan(2, 0, 8'h5A);
    repeat (6) step();
    chk("rd2w_trace", tr[23:0], 32'h18CCC2);
    // three back-to-back zero-wait commands
    for (int i = 0; i < 3; i++) begin q.push_back(CW'($urandom)); plan(0, 1'($urandom), DW'($urandom)); end
    repeat (8) step();
    chk("b2b_trace", tr[31:0], 32'h18DADAC2);
    repeat (2) step();
    chk("b2b_idle_busy", 32'(busy), 0);
    // timeout then a normal queued command
    q.push_back({1'b0, 8'h55, 8'h00}); plan(9, 0, 8'h00);
    q.push_back({1'b1, 8'h66, 8'h77}); plan(0, 0, 8'h00);
    repeat (8) step();
    chk("to_trace", tr[31:0], 32'h18CCCC38);
    repeat (2) step();
    chk("to_tail", tr[7:0], 32'hC2);
    // slave error on a read
    q.push_back({1'b0, 8'h20, 8'h00}); plan(0, 1, 8'hFF);
    repeat (5) step();
    // reset during ACCESS with the FIFO still non-empty
    q.push_back({1'b1, 8'h30, 8'h44}); plan(9, 0, 8'h00);
    q.push_back({1'b0, 8'h40, 8'h00});
    repeat (3) step();
    chk("pre_rst_access", 32'(psel && penable), 1);
    do_reset(2);
    repeat (12) step();
    // randomized traffic
    n_rsp = 0;
    repeat (800) begin
      if (q.size() < 4 && $urandom_range(0, 2) == 0) begin
        q.push_back(CW'($urandom));
        n_push++;
      end
      step();
    end
    for (int i = 0; i < 300 && (q.size() != 0 || cmd_q.size() != 0 || rsp_q.size() != 0 || busy); i++) step();
    chk("drain_fifo", q.size(), 0);
    chk("drain_rsp", rsp_q.size(), 0);
    chk("rsp_count", n_rsp, n_push);
    chk("end_busy", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
